mux_arbiter_2to1: RTL and testbench

Round-robin arbiter and sequencer for the shared one-bit 2:1 mux datapath (inputs a/b, select x, output y), widened to WIDTH bits. Two requesters compete for the single output y. The block grants one requester at a time, drives the mux select x, and registers the selected data with a valid flag. A hold counter bounds tenure so neither side can starve the other.

---
 rtl/mux_arb_pkg.sv | 24 ++
 rtl/mux_arbiter_2to1_mux.sv | 22 ++
 rtl/mux_arbiter_2to1.sv | 139 +++++++++++++
 tb/tb_mux_arbiter_2to1.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared encodings for the 2:1 mux arbiter
//
// Purpose: state and select encodings shared by the arbiter and its mux.
// Contents:
//   state_t     FSM state encoding (IDLE, OWN_A, OWN_B)
//   SEL_A/SEL_B mux select values (1 = a, 0 = b)
//   tie_winner  owner picked when both sides request from IDLE
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // A tie goes to whichever side did not own the output most recently.
  function automatic state_t tie_winner(input logic last_owner);
    return (last_owner == SEL_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/mux_arbiter_2to1_mux.sv
// rtl/mux_arbiter_2to1_mux.sv - WIDTH-bit 2:1 combinational mux
//
// Purpose: the shared mux datapath, widened from the one-bit original.
// Ports:
//   a  input  [WIDTH-1:0]  data selected when x == SEL_A
//   b  input  [WIDTH-1:0]  data selected when x == SEL_B
//   x  input               select
//   y  output [WIDTH-1:0]  selected data
module mux_nbit
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             x,
  output logic [WIDTH-1:0] y
);

  assign y = (x == SEL_A) ? a : b;

endmodule

// File: rtl/mux_arbiter_2to1.sv
// rtl/mux_arbiter_2to1.sv - round-robin arbiter driving a shared 2:1 mux
//
// Purpose: grants one of two requesters at a time, drives the mux select
// and registers the selected data with a valid flag. A hold counter bounds
// a contested tenure to MAX_HOLD cycles.
// Ports:
//   clk      input               rising-edge clock
//   reset_n  input               synchronous active-low reset
//   req_a    input               requester A wants the output
//   req_b    input               requester B wants the output
//   a        input  [WIDTH-1:0]  requester A data
//   b        input  [WIDTH-1:0]  requester B data
//   gnt_a    output              A owns the output
//   gnt_b    output              B owns the output
//   x        output              mux select (1 = a, 0 = b)
//   y        output [WIDTH-1:0]  registered mux output
//   y_valid  output              y carries granted data
module mux_arbiter_2to1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             x,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  // One bit minimum so MAX_HOLD == 1 still yields a legal vector.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;

  state_t           w_next_state;
  logic             w_contested;
  logic             w_hold_done;
  logic [WIDTH-1:0] w_mux_y;

  mux_nbit #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a(a),
    .b(b),
    .x(r_x),
    .y(w_mux_y)
  );

  // The owner's tenure is contested only while the other side requests.
  assign w_contested = ((r_state == OWN_A) && req_b) ||
                       ((r_state == OWN_B) && req_a);
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_a && req_b) begin
          w_next_state = tie_winner(r_last_owner);
        end else if (req_a) begin
          w_next_state = OWN_A;
        end else if (req_b) begin
          w_next_state = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          w_next_state = req_b ? OWN_B : IDLE;
        end else if (req_b && w_hold_done) begin
          w_next_state = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          w_next_state = req_a ? OWN_A : IDLE;
        end else if (req_a && w_hold_done) begin
          w_next_state = OWN_A;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_owner <= SEL_B;
      r_hold_cnt   <= '0;
      r_x          <= SEL_A;
      r_y          <= '0;
      r_y_valid    <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Output register follows the pre-edge select and state.
      r_y       <= w_mux_y;
      r_y_valid <= (r_state != IDLE);

      if (w_next_state != r_state) begin
        r_hold_cnt <= '0;
        // x only moves on entry to an owner state; IDLE keeps the last select.
        if (w_next_state == OWN_A) begin
          r_last_owner <= SEL_A;
          r_x          <= SEL_A;
        end else if (w_next_state == OWN_B) begin
          r_last_owner <= SEL_B;
          r_x          <= SEL_B;
        end
      end else if (w_contested) begin
        if (!w_hold_done) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end else begin
        // Uncontested owner never ages toward a forced handover.
        r_hold_cnt <= '0;
      end
    end
  end

  assign gnt_a   = (r_state == OWN_A);
  assign gnt_b   = (r_state == OWN_B);
  assign x       = r_x;
  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// tb/tb_mux_arbiter_2to1.sv - directed self-checking bench for mux_arbiter_2to1
module tb_mux_arbiter_2to1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_a;
  logic       req_b;
  logic       a;
  logic       b;
  logic [7:0] a8;
  logic [7:0] b8;

  logic       gnt_a, gnt_b, x, y, y_valid;
  logic       gnt_a1, gnt_b1, x1, y_valid1;
  logic [7:0] y1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_arbiter_2to1 #(
    .WIDTH(1),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_a(req_a),
    .req_b(req_b),
    .a(a),
    .b(b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .x(x),
    .y(y),
    .y_valid(y_valid)
  );

  mux_arbiter_2to1 #(
    .WIDTH(8),
    .MAX_HOLD(1)
  ) dut1 (
    .clk(clk),
    .reset_n(reset_n),
    .req_a(req_a),
    .req_b(req_b),
    .a(a8),
    .b(b8),
    .gnt_a(gnt_a1),
    .gnt_b(gnt_b1),
    .x(x1),
    .y(y1),
    .y_valid(y_valid1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ega, input logic egb,
                            input logic ex, input logic ey, input logic ev);
    check_eq({tag, ".gnt_a"},   32'(gnt_a),   32'(ega));
    check_eq({tag, ".gnt_b"},   32'(gnt_b),   32'(egb));
    check_eq({tag, ".x"},       32'(x),       32'(ex));
    check_eq({tag, ".y"},       32'(y),       32'(ey));
    check_eq({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
  endtask

  // Contention with MAX_HOLD=4, entered with A owning and hold_cnt=0.
  // Entry k is the value after the k+1-th contended edge.
  bit ga_tbl [16] = '{1,1,1,0, 0,0,0,1, 1,1,1,0, 0,0,0,1};
  bit y_tbl  [16] = '{1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0,0,0};

  initial begin
    reset_n = 1'b0;
    req_a   = 1'b1;
    req_b   = 1'b1;
    a       = 1'b1;
    b       = 1'b0;
    a8      = 8'hA5;
    b8      = 8'h3C;

    // Reset held 3 cycles with both requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Release: tie from reset goes to A; valid lags by one edge.
    reset_n = 1'b1;
    tick();
    check_eq("rel.gnt_a",   32'(gnt_a),   32'd1);
    check_eq("rel.gnt_b",   32'(gnt_b),   32'd0);
    check_eq("rel.y_valid", 32'(y_valid), 32'd0);
    req_b = 1'b0;
    tick();
    check_outs("rel2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // A alone keeps the grant with no timeout.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs("a_only", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Contention: 4-cycle tenures, y follows with one cycle lag.
    req_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq("cont.gnt_a",   32'(gnt_a),   32'(ga_tbl[k]));
      check_eq("cont.gnt_b",   32'(gnt_b),   32'(!ga_tbl[k]));
      check_eq("cont.x",       32'(x),       32'(ga_tbl[k]));
      check_eq("cont.y",       32'(y),       32'(y_tbl[k]));
      check_eq("cont.y_valid", 32'(y_valid), 32'd1);
    end

    // Early release at hold_cnt=1: direct handover, counter restarts.
    tick();
    check_eq("early.hold_a", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    tick();
    check_outs("early.hand", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("early.b_full", 32'(gnt_b), 32'd1);
    end
    tick();
    check_eq("early.back_a", 32'(gnt_a), 32'd1);

    // B served last, both drop, then a tie goes to A.
    req_a = 1'b0;
    tick();
    check_eq("tie.b_own", 32'(gnt_b), 32'd1);
    req_b = 1'b0;
    tick();
    check_outs("tie.idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("tie.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    check_eq("tie.gnt_a", 32'(gnt_a), 32'd1);
    check_eq("tie.gnt_b", 32'(gnt_b), 32'd0);

    // Mid-tenure reset while B owns with valid data.
    req_a = 1'b0;
    a     = 1'b0;
    b     = 1'b1;
    tick();
    tick();
    check_outs("mid.b_own", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    reset_n = 1'b0;
    tick();
    check_outs("mid.reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    req_a   = 1'b1;
    tick();
    check_eq("mid.tie_a", 32'(gnt_a), 32'd1);
    // After A served last, the next tie from IDLE goes to B.
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    check_eq("mid.idle", 32'(gnt_a | gnt_b), 32'd0);
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    check_eq("mid.tie_b", 32'(gnt_b), 32'd1);

    // MAX_HOLD=1, WIDTH=8: strict alternation, full-width data.
    reset_n = 1'b0;
    tick();
    check_eq("w8.reset_y", 32'(y1), 32'h00);
    reset_n = 1'b1;
    tick();
    check_eq("w8.first_a", 32'(gnt_a1),   32'd1);
    check_eq("w8.first_v", 32'(y_valid1), 32'd0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      check_eq("w8.gnt_a",   32'(gnt_a1),   32'((k % 2) == 1));
      check_eq("w8.gnt_b",   32'(gnt_b1),   32'((k % 2) == 0));
      check_eq("w8.y",       32'(y1),       (k % 2 == 0) ? 32'hA5 : 32'h3C);
      check_eq("w8.y_valid", 32'(y_valid1), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
